// File: rtl/mem_bus_responder_pkg.sv
// Shared memory map for the CPU-side word bus: I/O window base, register
// offsets inside the window and STATUS bit positions.
package mem_bus_responder_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFF0;

    // Register offsets inside the 16-word I/O window
    localparam int OFS_TX_DATA = 0;
    localparam int OFS_STATUS  = 1;
    localparam int OFS_DROP    = 2;

    // STATUS word layout
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_MSB = 15;

    // Decoded target of a bus address
    typedef enum logic [2:0] {
        TGT_NONE    = 3'd0,
        TGT_RAM     = 3'd1,
        TGT_TX_DATA = 3'd2,
        TGT_STATUS  = 3'd3,
        TGT_DROP    = 3'd4
    } target_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers. A push into a full FIFO is
// only taken when a pop happens on the same edge; otherwise it is dropped
// and the caller accounts for it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    // Head is masked while empty so the output reads zero after reset.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Accept pop only when data exists; accept push when room or a pop frees a slot
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU word bus. Writes are held in a pending
// register and committed when the write run ends (write drops or mar moves),
// so late write data from the initiator is still captured.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int                   BITS_DATA  = 32,
    parameter int                   BITS_ADDR  = 16,
    parameter int                   RAM_WORDS  = 1024,
    parameter logic [BITS_ADDR-1:0] IO_BASE    = BITS_ADDR'(IO_BASE_DEFAULT),
    parameter int                   FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] mar,
    input  logic [BITS_DATA-1:0] mbr_w,
    input  logic                 write,
    output logic [BITS_DATA-1:0] mbr_r,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BITS_ADDR:0]   RAM_LIMIT = (BITS_ADDR + 1)'(RAM_WORDS);
    localparam logic [BITS_ADDR-1:0] ADDR_TX   = IO_BASE + BITS_ADDR'(OFS_TX_DATA);
    localparam logic [BITS_ADDR-1:0] ADDR_STAT = IO_BASE + BITS_ADDR'(OFS_STATUS);
    localparam logic [BITS_ADDR-1:0] ADDR_DROP = IO_BASE + BITS_ADDR'(OFS_DROP);

    function automatic target_e decode(input logic [BITS_ADDR-1:0] addr);
        if ({1'b0, addr} < RAM_LIMIT) return TGT_RAM;
        if (addr == ADDR_TX)          return TGT_TX_DATA;
        if (addr == ADDR_STAT)        return TGT_STATUS;
        if (addr == ADDR_DROP)        return TGT_DROP;
        return TGT_NONE;
    endfunction

    logic [BITS_DATA-1:0] ram_q [RAM_WORDS];
    logic                 pending_q, pending_d;
    logic [BITS_ADDR-1:0] pend_addr_q, pend_addr_d;
    logic [BITS_DATA-1:0] pend_data_q, pend_data_d;
    logic [BITS_DATA-1:0] drop_cnt_q, drop_cnt_d;

    logic                 commit;
    target_e              pend_tgt, rd_tgt;
    logic                 ram_we, tx_push;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [BITS_DATA-1:0] status_word;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (out_ready),
        .din   (pend_data_q[7:0]),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

    // Commit detection, pending-run capture, commit routing and drop counting
    always_comb begin
        commit      = pending_q && (!write || (mar != pend_addr_q));
        pend_tgt    = decode(pend_addr_q);
        ram_we      = commit && (pend_tgt == TGT_RAM);
        tx_push     = commit && (pend_tgt == TGT_TX_DATA);
        // Every sampled write cycle (re)opens a run; a mar change starts a new one.
        pending_d   = write;
        pend_addr_d = write ? mar   : pend_addr_q;
        pend_data_d = write ? mbr_w : pend_data_q;
        drop_cnt_d  = drop_cnt_q;
        if (commit && (pend_tgt == TGT_DROP)) begin
            drop_cnt_d = '0;
        end else if (tx_push && fifo_full && !(out_valid && out_ready)
                     && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Pending-transaction and drop counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Word RAM, written only at commit and never reset
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_q[pend_addr_q[RAM_AW-1:0]] <= pend_data_q;
        end
    end

    // Zero-wait combinational read mux
    always_comb begin
        rd_tgt      = decode(mar);
        status_word = '0;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        case (rd_tgt)
            TGT_RAM:    mbr_r = ram_q[mar[RAM_AW-1:0]];
            TGT_STATUS: mbr_r = status_word;
            TGT_DROP:   mbr_r = drop_cnt_q;
            default:    mbr_r = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed bus transactions, expected read data
// and expected TX bytes queued by the driver, checked by a negedge monitor.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar;
    logic [31:0] mbr_w;
    logic        write;
    logic [31:0] mbr_r;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic        rd_req   = 1'b0;
    logic        idle_req = 1'b0;
    logic        end_req  = 1'b0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  exp_tx_q[$];

    int compared   = 0;
    int mismatched = 0;

    localparam logic [15:0] A_TX   = 16'hFFF0;
    localparam logic [15:0] A_STAT = 16'hFFF1;
    localparam logic [15:0] A_DROP = 16'hFFF2;

    mem_bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .mar       (mar),
        .mbr_w     (mbr_w),
        .write     (write),
        .mbr_r     (mbr_r),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor/scoreboard: all comparisons happen here on the falling edge
    always @(negedge clk) begin
        logic [31:0] e;
        logic [7:0]  eb;
        string       n;
        if (rd_req) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL rd_no_expect: mbr_r=%h with empty expected queue", mbr_r);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (mbr_r !== e) begin
                    mismatched++;
                    $display("FAIL %s: mbr_r=%h expected %h", n, mbr_r, e);
                end
            end
        end
        if (idle_req) begin
            compared++;
            if (out_valid !== 1'b0 || out_data !== 8'h00) begin
                mismatched++;
                $display("FAIL idle_out: out_valid=%b out_data=%h expected 0/00", out_valid, out_data);
            end
        end
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            compared++;
            if (exp_tx_q.size() == 0) begin
                mismatched++;
                $display("FAIL tx_unexpected: out_data=%h with no byte expected", out_data);
            end else begin
                eb = exp_tx_q.pop_front();
                if (out_data !== eb) begin
                    mismatched++;
                    $display("FAIL tx_byte: out_data=%h expected %h", out_data, eb);
                end
            end
        end
        if (end_req) begin
            compared++;
            if (exp_q.size() != 0 || exp_tx_q.size() != 0) begin
                mismatched++;
                $display("FAIL leftover: reads=%0d tx=%0d expected 0/0", exp_q.size(), exp_tx_q.size());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle write run followed by the commit edge
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        mar = a; mbr_w = d; write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    // Two-cycle write run with data changing in the second cycle
    task automatic bus_write_late(input logic [15:0] a, input logic [31:0] d0,
                                  input logic [31:0] d1);
        mar = a; mbr_w = d0; write = 1'b1;
        tick();
        mbr_w = d1;
        tick();
        write = 1'b0;
        tick();
    endtask

    task automatic read_chk(input logic [15:0] a, input logic [31:0] e, input string n);
        write = 1'b0; mar = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mar = '0; mbr_w = '0; write = 1'b0; out_ready = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset state
        idle_req = 1'b1; tick(); idle_req = 1'b0;
        read_chk(A_STAT, 32'h0000_0001, "reset_status");
        read_chk(A_DROP, 32'h0000_0000, "reset_drop");

        // RAM store/load with old value visible until commit
        bus_write(16'h0010, 32'h1234_5678);
        mar = 16'h0010; mbr_w = 32'h0; write = 1'b1;
        tick();
        mbr_w = 32'hDEAD_BEEF;
        exp_q.push_back(32'h1234_5678); name_q.push_back("ram_before_commit");
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        write = 1'b0; tick();
        read_chk(16'h0010, 32'hDEAD_BEEF, "ram_after_commit");

        // Late data to RAM
        bus_write_late(16'h0020, 32'h1111_1111, 32'h2222_2222);
        read_chk(16'h0020, 32'h2222_2222, "ram_late_data");

        // RAM boundary and mar change while write held
        bus_write(16'h03FF, 32'hCAFE_F00D);
        read_chk(16'h03FF, 32'hCAFE_F00D, "ram_last_word");
        read_chk(16'h0400, 32'h0000_0000, "first_unmapped");
        mar = 16'h0030; mbr_w = 32'hA0A0_A0A0; write = 1'b1; tick();
        mar = 16'h0031; mbr_w = 32'hB1B1_B1B1; tick();
        write = 1'b0; tick();
        read_chk(16'h0030, 32'hA0A0_A0A0, "run_split_old");
        read_chk(16'h0031, 32'hB1B1_B1B1, "run_split_new");

        // TX FIFO: late data pushes only once
        bus_write_late(A_TX, 32'h0000_0099, 32'h0000_0041); exp_tx_q.push_back(8'h41);
        bus_write(A_TX, 32'h0000_0042); exp_tx_q.push_back(8'h42);
        bus_write(A_TX, 32'h0000_0043); exp_tx_q.push_back(8'h43);
        read_chk(A_STAT, 32'h0000_0300, "status_three");
        read_chk(A_TX, 32'h0000_0000, "tx_data_reads_zero");
        out_ready = 1'b1; tick(4); out_ready = 1'b0;
        read_chk(A_STAT, 32'h0000_0001, "status_drained");

        // Overflow: 10 pushes, only first 8 kept
        for (int i = 0; i < 10; i++) begin
            bus_write(A_TX, 32'h0000_0050 + 32'(i));
            if (i < 8) exp_tx_q.push_back(8'h50 + 8'(i));
        end
        read_chk(A_STAT, 32'h0000_0802, "status_full");
        read_chk(A_DROP, 32'h0000_0002, "drop_two");
        bus_write(A_DROP, 32'hFFFF_FFFF);
        read_chk(A_DROP, 32'h0000_0000, "drop_cleared");

        // Full + push + pop on the same edge
        mar = A_TX; mbr_w = 32'h0000_0060; write = 1'b1; tick();
        write = 1'b0; out_ready = 1'b1; tick();
        out_ready = 1'b0;
        exp_tx_q.push_back(8'h60);
        read_chk(A_STAT, 32'h0000_0802, "status_full_pushpop");
        read_chk(A_DROP, 32'h0000_0000, "drop_pushpop");
        out_ready = 1'b1; tick(8); out_ready = 1'b0;
        read_chk(A_STAT, 32'h0000_0001, "status_after_drain");

        // Status write ignored, unmapped reads
        bus_write(A_STAT, 32'hFFFF_FFFF);
        read_chk(A_STAT, 32'h0000_0001, "status_write_ignored");
        read_chk(16'hFFF9, 32'h0000_0000, "unmapped_fff9");
        read_chk(16'h0800, 32'h0000_0000, "unmapped_0800");

        // Reset mid-transaction with a non-empty FIFO and non-zero drop count
        bus_write(16'h0005, 32'hAAAA_0005);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h0000_0070 + 32'(i));
        read_chk(A_DROP, 32'h0000_0001, "drop_before_reset");
        mar = 16'h0005; mbr_w = 32'h0000_0055; write = 1'b1; tick();
        reset = 1'b1; tick();
        reset = 1'b0; write = 1'b0; tick();
        idle_req = 1'b1; tick(); idle_req = 1'b0;
        read_chk(16'h0005, 32'hAAAA_0005, "ram_reset_discard");
        read_chk(A_STAT, 32'h0000_0001, "status_after_reset");
        read_chk(A_DROP, 32'h0000_0000, "drop_after_reset");

        end_req = 1'b1; tick(); end_req = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
Memory-side responder for the CPU's MAR/MBR_W/write/MBR_R word bus; the CPU is the initiator.
- Decodes each address to a word RAM or a small memory-mapped I/O window.
- The I/O window holds a byte TX FIFO drained by a downstream consumer through a valid/ready handshake, plus status and drop-count registers.
- Sits between the CPU and the top-level test harness, replacing a bare memory.

Parameters:
BITS_DATA, 32, data word width
BITS_ADDR, 16, word address width
RAM_WORDS, 1024, RAM depth in words; addresses 0..RAM_WORDS-1 map to RAM
IO_BASE, 16'hFFF0, base of the 16-word I/O window
FIFO_DEPTH, 8, TX FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
mar  in  BITS_ADDR  word address from initiator
mbr_w  in  BITS_DATA  write data from initiator
write  in  1  write request level
mbr_r  out  BITS_DATA  read data for mar
out_data  out  8  TX FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head byte

Behaviour:
- Reset (synchronous, active-high), state after the edge:
  - FIFO empty: out_valid=0, out_data=0.
  - drop_cnt=0; pending transaction cleared.
  - RAM contents are not reset.
  - mbr_r is combinational, so it carries no reset value of its own.
- Read path, combinational from mar and registered state; valid in the same cycle mar is stable (zero-wait, asynchronous read):
  - mar < RAM_WORDS: RAM[mar].
  - mar == IO_BASE+0 (TX_DATA): 0.
  - mar == IO_BASE+1 (STATUS): {zero-extend, count[7:0] at bits 15:8, bit1 full, bit0 empty}.
  - mar == IO_BASE+2 (DROP): drop_cnt.
  - Any other address: 0.
- Write transaction: a maximal run of consecutive cycles sampled with write=1 and unchanged mar.
  - Each write=1 edge latches pend_addr<=mar, pend_data<=mbr_w, pending<=1.
  - The initiator may present mbr_w up to one cycle after raising write. The last sampled mbr_w wins.
- Commit edge: the first edge with write=0 while pending=1, or with write=1 but mar != pend_addr.
  - At that edge, pend_data is applied to pend_addr and pending clears. If mar changed, the new run starts at the same edge.
  - Reads of pend_addr before commit return the old value.
  - From the cycle after commit, reads return the new value.
- Commit targets:
  - RAM: RAM[pend_addr] <= pend_data.
  - TX_DATA: push pend_data[7:0] into the FIFO.
  - DROP: drop_cnt <= 0.
  - STATUS and unmapped addresses: ignored.
- FIFO:
  - Pop on any edge with out_valid && out_ready.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge (full + push + pop leaves count unchanged).
  - A rejected push increments drop_cnt, saturating at all-ones.
  - Push and pop on the same edge from empty: the push wins, count=1 after the edge, and there is no pop because out_valid was 0.
  - out_data = head entry, registered pointers, wrap modulo FIFO_DEPTH.
  - Count is held in log2(FIFO_DEPTH)+1 bits.
- Reset during a pending transaction: the transaction is discarded and RAM is unchanged.
- Protocol contract: the initiator deasserts write before issuing the next fetch address.
  - If it does not, the mar change commits the old transaction and opens a new run at the new address.
  - This is deterministic, not an error flag.
- out_ready is ignored while out_valid=0.

Decomposition:
- Shared package/header (mem_map.vh): IO_BASE, the offsets OFS_TX_DATA=0, OFS_STATUS=1, OFS_DROP=2, and the STATUS bit positions. The CPU bench and software tests use the same file.
- One sub-module: sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated once for TX.
- The RAM array, decode, pending-transaction registers and drop_cnt live in mem_bus_responder.

Test Plan:
- RAM store/load: write=1 at mar=0x0010 for 2 cycles (mbr_w=X, then 0xDEADBEEF), then write=0 -> mbr_r at mar=0x0010 = 0xDEADBEEF from the cycle after the commit edge.
- Late-data store: raise write with mbr_w=0x11111111, change to 0x22222222 the next cycle, drop write -> RAM holds 0x22222222; one push only if the target is TX_DATA.
- TX FIFO: push 0x41,0x42,0x43 via TX_DATA with out_ready=0 -> STATUS=0x0300. Raise out_ready -> out_data 0x41,0x42,0x43 on consecutive cycles, then out_valid=0 and STATUS=0x0001.
- Overflow: 10 pushes with out_ready=0 and FIFO_DEPTH=8 -> STATUS=0x0802, DROP=2. Write DROP -> DROP=0. Full + push + simultaneous pop -> count stays 8, DROP unchanged.
- Reset mid-transaction: write=1 at mar=0x0005 with mbr_w=0x55, assert reset before write drops -> RAM[5] unchanged, FIFO empty, DROP=0.
- Unmapped and status access: read mar=0xFFF9 and 0x0800 -> 0. A write to STATUS leaves STATUS unchanged.
